// File: rtl/reg_wb_buffer.sv
// reg_wb_buffer: writeback-side buffer feeding the register file's write port.
// Latency: an entry accepted at edge t is written (Write_enable=1) after edge t+1.
// Backpressure: mem_ready while any slot is free; alu_ready needs one more slot when mem is valid.
module reg_wb_buffer #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                         CLK,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDR_BITS-1:0]         alu_reg,
  input  logic [DATA_BITS-1:0]         alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [ADDR_BITS-1:0]         mem_reg,
  input  logic [DATA_BITS-1:0]         mem_data,
  output logic                         mem_ready,
  output logic                         Write_enable,
  output logic [ADDR_BITS-1:0]         Write_reg,
  output logic [DATA_BITS-1:0]         Write_data,
  input  logic [ADDR_BITS-1:0]         Read_reg1,
  input  logic [ADDR_BITS-1:0]         Read_reg2,
  output logic                         fwd1_hit,
  output logic [DATA_BITS-1:0]         fwd1_data,
  output logic                         fwd2_hit,
  output logic [DATA_BITS-1:0]         fwd2_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO state
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DEPTH-1:0]     vld_q;
  logic [ADDR_BITS-1:0] ent_reg_q  [DEPTH];
  logic [DATA_BITS-1:0] ent_data_q [DEPTH];

  // Write stage
  logic                 wr_en_q;
  logic [ADDR_BITS-1:0] wr_reg_q;
  logic [DATA_BITS-1:0] wr_data_q;

  logic [CW-1:0]        free_slots;
  logic                 mem_fire, alu_fire;
  logic                 push_mem, push_alu, pop;
  logic [PW-1:0]        alu_slot;

  // The same-cycle pop is deliberately not credited so ready depends only on registered count
  assign free_slots = CW'(DEPTH) - count_q;
  assign mem_ready  = (free_slots >= CW'(1));
  assign alu_ready  = (free_slots >= (CW'(1) + CW'(mem_valid)));

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;
  // Register 0 results complete the handshake but are dropped
  assign push_mem = mem_fire && (mem_reg != '0);
  assign push_alu = alu_fire && (alu_reg != '0);
  assign pop      = (count_q != '0);

  // mem is older than alu when both land in the same cycle
  assign alu_slot = tail_q + PW'(push_mem);

  // Next-state pointers and occupancy
  always_comb begin
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push_mem) + PW'(push_alu);
    count_d = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
  end

  // Pointer, occupancy, valid-bit and write-stage registers
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      vld_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Push slots are always free slots, so they never collide with the popped head
      if (pop)      vld_q[head_q]   <= 1'b0;
      if (push_mem) vld_q[tail_q]   <= 1'b1;
      if (push_alu) vld_q[alu_slot] <= 1'b1;
      wr_en_q <= pop;
      if (pop) begin
        wr_reg_q  <= ent_reg_q[head_q];
        wr_data_q <= ent_data_q[head_q];
      end
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed
  always_ff @(posedge CLK) begin
    if (push_mem) begin
      ent_reg_q[tail_q]  <= mem_reg;
      ent_data_q[tail_q] <= mem_data;
    end
    if (push_alu) begin
      ent_reg_q[alu_slot]  <= alu_reg;
      ent_data_q[alu_slot] <= alu_data;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overrides; write stage is lowest priority
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (wr_en_q && (wr_reg_q == Read_reg1) && (Read_reg1 != '0)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = wr_data_q;
    end
    if (wr_en_q && (wr_reg_q == Read_reg2) && (Read_reg2 != '0)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (vld_q[idx] && (ent_reg_q[idx] == Read_reg1) && (Read_reg1 != '0)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = ent_data_q[idx];
      end
      if (vld_q[idx] && (ent_reg_q[idx] == Read_reg2) && (Read_reg2 != '0)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = ent_data_q[idx];
      end
    end
  end

  assign Write_enable = wr_en_q;
  assign Write_reg    = wr_reg_q;
  assign Write_data   = wr_data_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

endmodule
